// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared constants, press-FSM encoding and popcount helper for the keypad front end
package ttt_pkg;

  localparam int N_SQUARES = 9;
  localparam int N_ROWS    = 3;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    LOCKED   = 2'd2
  } press_state_t;

  function automatic logic [3:0] popcount9(input logic [N_SQUARES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < N_SQUARES; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for an asynchronous input bus
module sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 3x3 active-low keypad scanner with debounce, multi-key rejection and press strobe
module keypad_scanner
  import ttt_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [2:0] col,
  output logic [2:0] row,
  output logic [8:0] cuadro,
  output logic       key_pulse,
  output logic       multi_key
);

  localparam int                SLOT_W    = $clog2(SCAN_DIV);
  localparam int                STAB_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(DEBOUNCE_SCANS);
  localparam logic [1:0]        LAST_ROW  = 2'(N_ROWS - 1);

  logic [2:0]            col_q;
  logic [2:0]            col_s;
  logic [SLOT_W-1:0]     slot_cnt;
  logic [1:0]            row_idx;
  logic [N_SQUARES-1:0]  snapshot;
  logic [N_SQUARES-1:0]  snap_next;
  logic [N_SQUARES-1:0]  prev_scan;
  logic [N_SQUARES-1:0]  debounced;
  logic [STAB_W-1:0]     stable_cnt;
  logic [STAB_W-1:0]     stab_next;
  logic                  slot_last;

  press_state_t          state;
  press_state_t          state_next;
  logic [3:0]            pop;
  logic [N_SQUARES-1:0]  cuadro_d;
  logic                  pulse_d;
  logic                  multi_d;

  // Synchroniser idles at the pulled-up level so reset does not look like a press.
  sync2 #(
    .WIDTH     (3),
    .RESET_VAL (3'b111)
  ) u_col_sync (
    .clk   (clk_100MHz),
    .rst_n (reset),
    .d     (col),
    .q     (col_q)
  );

  assign col_s     = ~col_q;
  assign row       = ~(3'b001 << row_idx);
  assign slot_last = (slot_cnt == SLOT_LAST);

  always_comb begin
    snap_next = snapshot;
    case (row_idx)
      2'd0:    snap_next[2:0] = col_s;
      2'd1:    snap_next[5:3] = col_s;
      default: snap_next[8:6] = col_s;
    endcase
  end

  always_comb begin
    stab_next = STAB_W'(1);
    if (snap_next == prev_scan) begin
      stab_next = (stable_cnt == STAB_MAX) ? STAB_MAX : stable_cnt + STAB_W'(1);
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      slot_cnt   <= '0;
      row_idx    <= '0;
      snapshot   <= '0;
      prev_scan  <= '0;
      debounced  <= '0;
      stable_cnt <= '0;
    end else if (slot_last) begin
      slot_cnt <= '0;
      row_idx  <= (row_idx == LAST_ROW) ? 2'd0 : row_idx + 2'd1;
      snapshot <= snap_next;
      // Row-2 sample closes a full scan; debounce against the previous one.
      if (row_idx == LAST_ROW) begin
        stable_cnt <= stab_next;
        if (snap_next != prev_scan) begin
          prev_scan <= snap_next;
        end
        if (stab_next == STAB_MAX) begin
          debounced <= snap_next;
        end
      end
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  assign pop = popcount9(debounced);

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state <= RELEASED;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RELEASED: begin
        if (pop == 4'd1)      state_next = PRESSED;
        else if (pop >= 4'd2) state_next = LOCKED;
      end
      PRESSED: begin
        if (pop == 4'd0)      state_next = RELEASED;
        else if (pop >= 4'd2) state_next = LOCKED;
      end
      LOCKED: begin
        if (pop == 4'd0)      state_next = RELEASED;
      end
      default: state_next = RELEASED;
    endcase
  end

  // LOCKED holds cuadro at zero until every key is released.
  always_comb begin
    cuadro_d = '0;
    if (state_next == PRESSED) begin
      cuadro_d = debounced;
    end
    pulse_d = (state == RELEASED) && (pop == 4'd1);
    multi_d = (pop >= 4'd2);
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      cuadro    <= '0;
      key_pulse <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      cuadro    <= cuadro_d;
      key_pulse <= pulse_d;
      multi_key <= multi_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench driving a modelled 3x3 keypad into keypad_scanner
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] col;
  logic [2:0] row;
  logic [8:0] cuadro;
  logic       key_pulse;
  logic       multi_key;
  logic [8:0] keys = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [10:0] exp_q[$];
  logic [9:0]  last_out = '0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .col        (col),
    .row        (row),
    .cuadro     (cuadro),
    .key_pulse  (key_pulse),
    .multi_key  (multi_key)
  );

  // Passive matrix: a column reads low when a held key sits on the driven row.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      col[c] = 1'b1;
      for (int r = 0; r < 3; r++) begin
        if (keys[r*3+c] && !row[r]) col[c] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [10:0] cur;
    logic [10:0] e;
    cur = {cuadro, multi_key, key_pulse};
    if ({cuadro, multi_key} != last_out || key_pulse) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL event: got cuadro=%h multi=%b pulse=%b, required no output change",
                 cuadro, multi_key, key_pulse);
      end else begin
        e = exp_q.pop_front();
        if (e != cur) begin
          miscompares++;
          $display("FAIL event: got cuadro=%h multi=%b pulse=%b, required cuadro=%h multi=%b pulse=%b",
                   cuadro, multi_key, key_pulse, e[10:2], e[1], e[0]);
        end
      end
    end
    last_out = {cuadro, multi_key};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [8:0] c, input logic m, input logic p);
    exp_q.push_back({c, m, p});
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expected events still pending after %0d cycles, required 0",
               exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic set_keys(input logic [8:0] k);
    @(posedge clk);
    #2;
    keys = k;
  endtask

  logic [2:0] exp_rows [3] = '{3'b110, 3'b101, 3'b011};
  logic [8:0] rst_keys [6] = '{9'h010, 9'h000, 9'h1FF, 9'h101, 9'h000, 9'h080};

  initial begin
    // Scenario 1: reset held while the keypad toggles.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #2;
      keys = rst_keys[i];
      @(negedge clk);
      check("reset_row", 32'(row), 32'(3'b110));
      check("reset_cuadro", 32'(cuadro), 32'h0);
      check("reset_pulse", 32'(key_pulse), 32'h0);
      check("reset_multi", 32'(multi_key), 32'h0);
    end
    keys = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      check("row_seq", 32'(row), 32'(exp_rows[(n / 4) % 3]));
    end

    // Scenario 2: key 4 held then released.
    expect_ev(9'h010, 1'b0, 1'b1);
    set_keys(9'h010);
    wait_drain(40);
    repeat (20) @(posedge clk);
    expect_ev(9'h000, 1'b0, 1'b0);
    set_keys(9'h000);
    wait_drain(40);
    repeat (30) @(posedge clk);

    // Scenario 3: key 0 with an on/off/on bounce.
    expect_ev(9'h001, 1'b0, 1'b1);
    set_keys(9'h001);
    set_keys(9'h000);
    set_keys(9'h001);
    wait_drain(40);
    repeat (30) @(posedge clk);
    expect_ev(9'h000, 1'b0, 1'b0);
    set_keys(9'h000);
    wait_drain(40);
    repeat (30) @(posedge clk);

    // Scenario 4: keys 0+8 lock out, partial release stays locked.
    expect_ev(9'h000, 1'b1, 1'b0);
    set_keys(9'h101);
    wait_drain(40);
    expect_ev(9'h000, 1'b0, 1'b0);
    set_keys(9'h001);
    wait_drain(40);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("locked_cuadro", 32'(cuadro), 32'h0);
    set_keys(9'h000);
    repeat (40) @(posedge clk);
    expect_ev(9'h004, 1'b0, 1'b1);
    set_keys(9'h004);
    wait_drain(40);
    expect_ev(9'h000, 1'b0, 1'b0);
    set_keys(9'h000);
    wait_drain(40);
    repeat (30) @(posedge clk);

    // Scenario 5: slide from key 3 to key 5.
    expect_ev(9'h008, 1'b0, 1'b1);
    set_keys(9'h008);
    wait_drain(40);
    expect_ev(9'h020, 1'b0, 1'b0);
    set_keys(9'h020);
    wait_drain(40);
    expect_ev(9'h000, 1'b0, 1'b0);
    set_keys(9'h000);
    wait_drain(40);
    repeat (30) @(posedge clk);

    // Scenario 6: asynchronous reset while key 7 is held.
    expect_ev(9'h080, 1'b0, 1'b1);
    set_keys(9'h080);
    wait_drain(40);
    repeat (5) @(posedge clk);
    expect_ev(9'h000, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_cuadro", 32'(cuadro), 32'h0);
    check("async_row", 32'(row), 32'(3'b110));
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_drain(5);
    expect_ev(9'h080, 1'b0, 1'b1);
    wait_drain(40);
    expect_ev(9'h000, 1'b0, 1'b0);
    set_keys(9'h000);
    wait_drain(40);
    repeat (20) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
